// File: rtl/ternary_pkg.sv
// ternary_pkg: shared types and constants for the ternary matrix-vector engine.
//   state_t      - sequencer states (IDLE, CLEAR, MULT, DRAIN, OUT)
//   MaxInLen     - MAC rows, MaxOutLen - MAC columns, InW/OutW their index widths
//   IDLE_TO_LOAD - top-level FSM opcode
//   sat_inc      - 16-bit saturating increment
package ternary_pkg;
    localparam int MaxInLen = 16;
    localparam int MaxOutLen = 8;
    localparam int InW = $clog2(MaxInLen);
    localparam int OutW = $clog2(MaxOutLen);
    localparam logic [3:0] IDLE_TO_LOAD = 4'hA;

    typedef enum logic [2:0] {
        IDLE,
        CLEAR,
        MULT,
        DRAIN,
        OUT
    } state_t;

    function automatic logic [15:0] sat_inc(input logic [15:0] v);
        return (&v) ? v : v + 16'd1;
    endfunction
endpackage

// File: rtl/ternary_out_seq.sv
// ternary_out_seq: OUT-phase column counter with valid/ready presentation.
//   clk, rst  - clock, asynchronous active-high reset
//   start_i   - begin presenting from column 0
//   len_i     - number of columns minus 1
//   ready_i   - consumer accepts the current column
//   valid_o   - column sel_o is valid
//   sel_o     - column being presented
//   last_o    - the final column is accepted this cycle
module ternary_out_seq
    import ternary_pkg::*;
#(
    parameter int W = OutW
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start_i,
    input  logic [W-1:0] len_i,
    input  logic         ready_i,
    output logic         valid_o,
    output logic [W-1:0] sel_o,
    output logic         last_o
);
    logic         valid_q, valid_d;
    logic [W-1:0] sel_q, sel_d;

    always_comb begin
        last_o  = valid_q && ready_i && (sel_q == len_i);
        valid_d = start_i ? 1'b1 : last_o ? 1'b0 : valid_q;
        sel_d   = (start_i || last_o) ? '0 : (valid_q && ready_i) ? sel_q + 1'b1 : sel_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q <= 1'b0;
            sel_q   <= '0;
        end else begin
            valid_q <= valid_d;
            sel_q   <= sel_d;
        end
    end

    assign valid_o = valid_q;
    assign sel_o   = sel_q;
endmodule

// File: rtl/ternary_mult_ctrl.sv
// ternary_mult_ctrl: MULT/OUT phase sequencer for the ternary MAC array.
//   start/cfg_in_len/cfg_out_len/weights_ready - operation request and lengths (minus 1)
//   in_valid/in_data/in_ready                  - activation stream, two int8 rows per beat
//   mac_clr/mac_en/mac_row/mac_act/mac_pair    - MAC array control
//   out_sel/out_valid/out_ready                - accumulator column presentation
//   busy/done/err                              - status; perf_cycles - last operation length
// Build option: TERNARY_CTRL_PERF_EN enables the perf_cycles counter (tied to 0 otherwise).
module ternary_mult_ctrl #(
    parameter int MaxInLen = ternary_pkg::MaxInLen,
    parameter int MaxOutLen = ternary_pkg::MaxOutLen,
    parameter int MacLat = 2
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         start,
    input  logic [$clog2(MaxInLen)-1:0]  cfg_in_len,
    input  logic [$clog2(MaxOutLen)-1:0] cfg_out_len,
    input  logic                         weights_ready,
    input  logic                         in_valid,
    input  logic [15:0]                  in_data,
    output logic                         in_ready,
    output logic                         mac_clr,
    output logic                         mac_en,
    output logic [$clog2(MaxInLen)-1:0]  mac_row,
    output logic [15:0]                  mac_act,
    output logic                         mac_pair,
    output logic [$clog2(MaxOutLen)-1:0] out_sel,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic                         busy,
    output logic                         done,
    output logic                         err,
    output logic [15:0]                  perf_cycles
);
    import ternary_pkg::*;

    localparam int IW = $clog2(MaxInLen);
    localparam int OW = $clog2(MaxOutLen);
    localparam int DW = $clog2(MacLat + 1);

    state_t          state_q, state_d;
    logic [IW-1:0]   in_len_q;
    logic [OW-1:0]   out_len_q;
    logic [IW-2:0]   b_q, b_d;
    logic [DW-1:0]   d_q, d_d;
    logic [IW-1:0]   row;
    logic            accept, last_beat, drain_end, out_last, launch;
    logic            mac_en_q, mac_pair_q, done_q, err_q;
    logic [IW-1:0]   mac_row_q;
    logic [15:0]     mac_act_q;

    assign row       = {b_q, 1'b0};
    assign accept    = (state_q == MULT) && in_valid;
    // The beat holding row in_len (or in_len-1) is the last one.
    assign last_beat = (b_q == in_len_q[IW-1:1]);
    // One cycle for the final mac_en beat, then MacLat cycles for it to land.
    assign drain_end = (state_q == DRAIN) && (d_q == DW'(MacLat));
    assign launch    = (state_q == IDLE) && start && weights_ready;

    always_comb begin
        state_d = state_q;
        b_d     = b_q;
        d_d     = d_q;
        unique case (state_q)
            IDLE:  if (launch) state_d = CLEAR;
            CLEAR: begin
                state_d = MULT;
                b_d     = '0;
            end
            MULT: if (in_valid) begin
                b_d = b_q + 1'b1;
                if (last_beat) begin
                    state_d = DRAIN;
                    b_d     = '0;
                    d_d     = '0;
                end
            end
            DRAIN: begin
                d_d = d_q + 1'b1;
                if (drain_end) begin
                    state_d = OUT;
                    d_d     = '0;
                end
            end
            OUT:   if (out_last) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            in_len_q   <= '0;
            out_len_q  <= '0;
            b_q        <= '0;
            d_q        <= '0;
            mac_en_q   <= 1'b0;
            mac_row_q  <= '0;
            mac_act_q  <= '0;
            mac_pair_q <= 1'b0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state_q  <= state_d;
            b_q      <= b_d;
            d_q      <= d_d;
            mac_en_q <= accept;
            done_q   <= out_last;
            err_q    <= (state_q == IDLE) && start && !weights_ready;
            if (launch) begin
                in_len_q  <= cfg_in_len;
                out_len_q <= cfg_out_len;
            end
            if (accept) begin
                mac_row_q  <= row;
                mac_act_q  <= in_data;
                mac_pair_q <= (row != in_len_q);
            end
        end
    end

    ternary_out_seq #(.W(OW)) u_out (
        .clk     (clk),
        .rst     (rst),
        .start_i (drain_end),
        .len_i   (out_len_q),
        .ready_i (out_ready),
        .valid_o (out_valid),
        .sel_o   (out_sel),
        .last_o  (out_last)
    );

    assign in_ready = (state_q == MULT);
    assign mac_clr  = (state_q == CLEAR);
    assign busy     = (state_q != IDLE);
    assign mac_en   = mac_en_q;
    assign mac_row  = mac_row_q;
    assign mac_act  = mac_act_q;
    assign mac_pair = mac_pair_q;
    assign done     = done_q;
    assign err      = err_q;

`ifdef TERNARY_CTRL_PERF_EN
    logic [15:0] pc_q, perf_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc_q   <= '0;
            perf_q <= '0;
        end else begin
            if (launch) pc_q <= '0;
            else if (busy) pc_q <= sat_inc(pc_q);
            // Include the final OUT cycle, which is still counting this edge.
            if (out_last) perf_q <= sat_inc(pc_q);
        end
    end

    assign perf_cycles = perf_q;
`else
    assign perf_cycles = '0;
`endif
endmodule

// File: tb/tb_ternary_mult_ctrl.sv
// tb_ternary_mult_ctrl: self-checking bench for ternary_mult_ctrl.
module tb_ternary_mult_ctrl;
    logic        clk = 1'b0;
    logic        rst, start, weights_ready, in_valid, out_ready;
    logic [3:0]  cfg_in_len;
    logic [2:0]  cfg_out_len;
    logic [15:0] in_data;
    logic        in_ready, mac_clr, mac_en, mac_pair, out_valid, busy, done, err;
    logic [3:0]  mac_row;
    logic [15:0] mac_act, perf_cycles;
    logic [2:0]  out_sel;

    always #5 clk = ~clk;

    ternary_mult_ctrl dut (
        .clk(clk), .rst(rst), .start(start), .cfg_in_len(cfg_in_len), .cfg_out_len(cfg_out_len),
        .weights_ready(weights_ready), .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
        .mac_clr(mac_clr), .mac_en(mac_en), .mac_row(mac_row), .mac_act(mac_act), .mac_pair(mac_pair),
        .out_sel(out_sel), .out_valid(out_valid), .out_ready(out_ready), .busy(busy), .done(done),
        .err(err), .perf_cycles(perf_cycles)
    );

    typedef struct {
        int in_m1;
        int out_m1;
        bit rnd;
        int stall_col;
        int exp_beats;
        int exp_lat;
        int exp_busy;
    } vec_t;

    typedef struct {
        logic [3:0]  row;
        logic [15:0] act;
        logic        pair;
    } beat_t;

    vec_t  vt[7];
    beat_t bq[$];
    int    oq[$];
    int    n_vec = 0, n_bad = 0;
    int    n_en = 0, n_clr = 0, n_done = 0, n_errp = 0, n_busy = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic mon();
        beat_t b;
        if (int'(mac_en) + int'(mac_clr) + int'(out_valid) > 1)
            chk("exclusive_strobes", int'(mac_en) + int'(mac_clr) + int'(out_valid), 1);
        if (mac_en) begin
            n_en++;
            if (bq.size() == 0) chk("mac_en_unexpected", 1, 0);
            else begin
                b = bq.pop_front();
                chk("mac_row", mac_row, b.row);
                chk("mac_act", mac_act, b.act);
                chk("mac_pair", mac_pair, b.pair);
            end
        end
        if (mac_clr) n_clr++;
        if (done) n_done++;
        if (err) n_errp++;
        if (busy) n_busy++;
    endtask

    task automatic tick();
        @(negedge clk);
        mon();
    endtask

    task automatic run(input vec_t v);
        int beat = 0, stall = 3, lat = -1, t = 1;
        int en0 = n_en, clr0 = n_clr, done0 = n_done, err0 = n_errp, busy0 = n_busy;
        bit fin = 0;
        beat_t b;
        for (int c = 0; c <= v.out_m1; c++) oq.push_back(c);
        cfg_in_len = 4'(v.in_m1);
        cfg_out_len = 3'(v.out_m1);
        start = 1'b1;
        weights_ready = 1'b1;
        in_valid = 1'b0;
        out_ready = 1'b0;
        tick();
        start = 1'b0;
        cfg_in_len = 4'($urandom);
        cfg_out_len = 3'($urandom);
        while (t < 400 && !fin) begin
            start = (t == 4);
            weights_ready = (t != 4);
            in_valid = v.rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            in_data = 16'($urandom);
            if (in_valid && in_ready) begin
                b.row = 4'(2 * beat);
                b.act = in_data;
                b.pair = (2 * beat != v.in_m1);
                bq.push_back(b);
                beat++;
            end
            if (stall > 0 && stall < 3) begin
                chk("stall_sel_hold", out_sel, v.stall_col);
                chk("stall_valid_hold", out_valid, 1);
                out_ready = 1'b0;
                stall--;
            end else if (stall == 3 && out_valid && out_sel == v.stall_col) begin
                out_ready = 1'b0;
                stall--;
            end else out_ready = v.rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            if (out_valid && out_ready) begin
                if (oq.size() == 0) chk("extra_column", 1, 0);
                else chk("out_sel", out_sel, oq.pop_front());
            end
            tick();
            t++;
            if (out_valid && lat < 0) lat = t - 1;
            if (done) fin = 1;
        end
        start = 1'b0;
        weights_ready = 1'b1;
        in_valid = 1'b0;
        out_ready = 1'b0;
        chk("done_reached", fin, 1);
`ifdef TERNARY_CTRL_PERF_EN
        chk("perf_cycles", perf_cycles, n_busy - busy0);
`else
        chk("perf_cycles_off", perf_cycles, 0);
`endif
        if (v.exp_lat >= 0) chk("first_out_latency", lat, v.exp_lat);
        if (v.exp_busy >= 0) chk("busy_cycles", n_busy - busy0, v.exp_busy);
        chk("beats_driven", beat, v.exp_beats);
        chk("mac_en_count", n_en - en0, v.exp_beats);
        chk("mac_clr_count", n_clr - clr0, 1);
        chk("err_outside_idle", n_errp - err0, 0);
        chk("beats_pending", bq.size(), 0);
        chk("columns_pending", oq.size(), 0);
        tick();
        chk("done_pulse_width", n_done - done0, 1);
        chk("idle_after_done", {busy, out_valid, in_ready}, 0);
        bq.delete();
        oq.delete();
    endtask

    initial begin
        int e0, bad;
        beat_t b;
        vt[0] = '{15, 7, 1'b0, -1, 8, 12, 20};
        vt[1] = '{4, 3, 1'b0, -1, 3, 7, 11};
        vt[2] = '{1, 0, 1'b0, -1, 1, 5, 6};
        vt[3] = '{0, 0, 1'b0, -1, 1, 5, 6};
        vt[4] = '{3, 1, 1'b0, 1, 2, 6, 11};
        vt[5] = '{15, 7, 1'b1, 2, 8, -1, -1};
        vt[6] = '{6, 5, 1'b1, 2, 4, -1, -1};

        rst = 1'b1;
        start = 1'b0;
        weights_ready = 1'b0;
        in_valid = 1'b0;
        out_ready = 1'b0;
        cfg_in_len = '0;
        cfg_out_len = '0;
        in_data = '0;
        repeat (2) @(negedge clk);
        chk("reset_outputs", {in_ready, mac_clr, mac_en, mac_row, mac_act, mac_pair, out_sel,
                              out_valid, busy, done, err, perf_cycles}, 0);
        rst = 1'b0;
        tick();
        chk("idle_outputs", {in_ready, mac_clr, mac_en, out_valid, busy, done, err}, 0);

        e0 = n_errp;
        bad = 0;
        start = 1'b1;
        in_valid = 1'b1;
        tick();
        start = 1'b0;
        bad |= {busy, in_ready, mac_clr, mac_en};
        repeat (5) begin
            tick();
            bad |= {busy, in_ready, mac_clr, mac_en};
        end
        in_valid = 1'b0;
        chk("err_pulse_count", n_errp - e0, 1);
        chk("no_activity_on_err", bad, 0);

        foreach (vt[i]) run(vt[i]);

        e0 = n_en;
        cfg_in_len = 4'd15;
        cfg_out_len = 3'd7;
        weights_ready = 1'b1;
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int k = 0, g = 0; k < 3 && g < 20; g++) begin
            in_valid = 1'b1;
            in_data = 16'($urandom);
            if (in_ready) begin
                b.row = 4'(2 * k);
                b.act = in_data;
                b.pair = 1'b1;
                bq.push_back(b);
                k++;
            end
            tick();
        end
        in_valid = 1'b0;
        chk("beats_before_reset", n_en - e0, 3);
        #2 rst = 1'b1;
        #1 chk("async_reset_outputs", {in_ready, mac_clr, mac_en, mac_row, mac_act, mac_pair, out_sel,
                                       out_valid, busy, done, err, perf_cycles}, 0);
        bq.delete();
        oq.delete();
        @(negedge clk);
        rst = 1'b0;
        tick();
        run(vt[0]);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
